// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_wb_scheduler_pkg;

  localparam int              REG_W    = 4;
  localparam logic [REG_W-1:0] RNONE   = 4'hF;
  localparam logic [REG_W-1:0] RSP     = 4'h4;
  localparam int              BUNDLE_W = 136;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_E = 2'd1,
    WR_M = 2'd2
  } wb_state_e;

  // One write-back bundle: ALU result and memory result with their targets.
  typedef struct packed {
    logic [REG_W-1:0] dst_e;
    logic [63:0]      val_e;
    logic [REG_W-1:0] dst_m;
    logic [63:0]      val_m;
  } wb_bundle_t;

  // First write phase a bundle needs; bundles with no destination never reach here.
  function automatic wb_state_e first_state(input wb_bundle_t b);
    return (b.dst_e != RNONE) ? WR_E : WR_M;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_fifo.sv
// Write-back bundle buffer: DEPTH-entry circular FIFO of 136-bit bundles.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: full is raised at DEPTH entries; the caller must not push when full.
module wb_bundle_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 136
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic         multi,
  output logic [W-1:0] head_dat,
  output logic [W-1:0] sec_dat
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next storage, pointers and occupancy from push/pop.
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = inc_ptr(wr_q);
    end
    if (pop) begin
      rd_d = inc_ptr(rd_q);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Buffer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign multi    = (cnt_q > CW'(1));
  assign head_dat = mem_q[rd_q];
  // Entry behind the head; only meaningful when multi is set.
  assign sec_dat  = mem_q[inc_ptr(rd_q)];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Serialises write-back bundles (dstE then dstM) onto a single register-file write port.
// Latency: first write the cycle after acceptance into an idle scheduler; one write per cycle sustained.
// Backpressure: wb_ready drops while the bundle buffer is full, independent of a same-cycle pop.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREG  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [REG_W-1:0] wb_dstE,
  input  logic [63:0]      wb_valE,
  input  logic [REG_W-1:0] wb_dstM,
  input  logic [63:0]      wb_valM,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_waddr,
  output logic [63:0]      rf_wdata,
  input  logic [REG_W-1:0] rd_srcA,
  input  logic [REG_W-1:0] rd_srcB,
  output logic             rd_stall,
  output logic [NREG-1:0]  pend_mask,
  output logic             busy
);

  // Counters must cover every write of a full buffer (two per bundle).
  localparam int CW = $clog2(2 * DEPTH + 1);

  wb_state_e     state_q, state_d, after_pop;
  wb_bundle_t    in_b, head_b, sec_b;
  logic          push, pop, full, empty, multi;
  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];

  assign in_b = '{dst_e: wb_dstE, val_e: wb_valE, dst_m: wb_dstM, val_m: wb_valM};

  assign wb_ready = !full;
  // Bundles with no destination are accepted and dropped on the floor.
  assign push = wb_valid && wb_ready && !((wb_dstE == RNONE) && (wb_dstM == RNONE));

  wb_bundle_fifo #(
    .DEPTH (DEPTH),
    .W     (BUNDLE_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (in_b),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .multi    (multi),
    .head_dat (head_b),
    .sec_dat  (sec_b)
  );

  // Phase after retiring the head: the next buffered bundle, else one arriving this cycle.
  always_comb begin
    after_pop = IDLE;
    if (multi) after_pop = first_state(sec_b);
    else if (push) after_pop = first_state(in_b);
  end

  // Write-phase FSM next state and write-port drive.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = RNONE;
    rf_wdata = '0;
    case (state_q)
      IDLE: begin
        // A bundle arriving into an empty buffer is scheduled straight away.
        if (!empty) state_d = first_state(head_b);
        else if (push) state_d = first_state(in_b);
      end
      WR_E: begin
        rf_we    = 1'b1;
        rf_waddr = head_b.dst_e;
        rf_wdata = head_b.val_e;
        if (head_b.dst_m != RNONE) begin
          state_d = WR_M;
        end else begin
          pop     = 1'b1;
          state_d = after_pop;
        end
      end
      WR_M: begin
        rf_we    = 1'b1;
        rf_waddr = head_b.dst_m;
        rf_wdata = head_b.val_m;
        pop      = 1'b1;
        state_d  = after_pop;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Pending counts: enqueue increments and the current write's decrement net out.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i]
               + CW'(push && (wb_dstE == REG_W'(i)))
               + CW'(push && (wb_dstM == REG_W'(i)))
               - CW'(rf_we && (rf_waddr == REG_W'(i)));
    end
  end

  // Pending counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Pending mask and decode stall; RNONE and out-of-range IDs never match a counter.
  always_comb begin
    pend_mask = '0;
    rd_stall  = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      pend_mask[i] = (cnt_q[i] != '0);
      if (pend_mask[i] && ((rd_srcA == REG_W'(i)) || (rd_srcB == REG_W'(i)))) rd_stall = 1'b1;
    end
  end

  assign busy = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  localparam int DEPTH = 2;
  localparam int NREG  = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wb_valid = 1'b0;
  logic            wb_ready;
  logic [3:0]      wb_dstE = 4'hF;
  logic [63:0]     wb_valE = '0;
  logic [3:0]      wb_dstM = 4'hF;
  logic [63:0]     wb_valM = '0;
  logic            rf_we;
  logic [3:0]      rf_waddr;
  logic [63:0]     rf_wdata;
  logic [3:0]      rd_srcA = 4'hF;
  logic [3:0]      rd_srcB = 4'hF;
  logic            rd_stall;
  logic [NREG-1:0] pend_mask;
  logic            busy;

  regfile_wb_scheduler #(.DEPTH(DEPTH), .NREG(NREG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_dstE   (wb_dstE),
    .wb_valE   (wb_valE),
    .wb_dstM   (wb_dstM),
    .wb_valM   (wb_valM),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rd_srcA   (rd_srcA),
    .rd_srcB   (rd_srcB),
    .rd_stall  (rd_stall),
    .pend_mask (pend_mask),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: ordered list of register writes still owed by accepted bundles.
  typedef struct {
    logic [3:0]  a;
    logic [63:0] d;
    bit          last;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  saw_not_ready = 0;
  bit  rand_src = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREG-1:0] model_mask();
    logic [NREG-1:0] m = '0;
    foreach (exp_q[i]) if (int'(exp_q[i].a) < NREG) m[exp_q[i].a] = 1'b1;
    return m;
  endfunction

  function automatic int model_bundles();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].last) n++;
    return n;
  endfunction

  function automatic bit is_pend(input logic [NREG-1:0] m, input logic [3:0] s);
    if (int'(s) >= NREG) return 1'b0;
    return m[s];
  endfunction

  task automatic model_push(input logic [3:0] de, input logic [63:0] ve,
                            input logic [3:0] dm, input logic [63:0] vm);
    if (de != 4'hF) exp_q.push_back('{a: de, d: ve, last: (dm == 4'hF)});
    if (dm != 4'hF) exp_q.push_back('{a: dm, d: vm, last: 1'b1});
  endtask

  // Monitor: mid-cycle comparison of every output against the model, then retire the write.
  initial begin
    forever begin
      logic [NREG-1:0] m;
      bit              exp_stall;
      @(negedge clk);
      m = model_mask();
      exp_stall = is_pend(m, rd_srcA) || is_pend(m, rd_srcB);
      chk("rf_we", rf_we, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("rf_waddr", rf_waddr, exp_q[0].a);
        chk("rf_wdata", rf_wdata, exp_q[0].d);
      end else begin
        chk("idle_waddr", rf_waddr, 4'hF);
        chk("idle_wdata", rf_wdata, 64'h0);
      end
      chk("pend_mask", pend_mask, m);
      chk("rd_stall", rd_stall, exp_stall);
      chk("busy", busy, exp_q.size() != 0);
      chk("wb_ready", wb_ready, model_bundles() < DEPTH);
      if (!wb_ready) saw_not_ready = 1'b1;
      if (rf_we && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  // Decode-source driver for the randomized phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_src) begin
        rd_srcA = 4'($urandom_range(0, 15));
        rd_srcB = 4'($urandom_range(0, 15));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one bundle and hold it until accepted; acceptance feeds the model.
  task automatic send(input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
    bit acc = 0;
    int n = 0;
    wb_valid = 1'b1;
    wb_dstE  = de;
    wb_valE  = ve;
    wb_dstM  = dm;
    wb_valM  = vm;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = wb_ready;
      n++;
      @(posedge clk);
      if (acc) model_push(de, ve, dm, vm);
      #1;
    end
    wb_valid = 1'b0;
    chk("accept_timeout", acc, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      idle(1);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  function automatic logic [3:0] rnd_dst();
    if ($urandom_range(0, 4) == 0) return 4'hF;
    return 4'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    // Reset values while held in reset.
    #2;
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_waddr", rf_waddr, 4'hF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pend", pend_mask, '0);
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Single ALU write.
    send(4'd3, 64'h55, 4'hF, 64'h0);
    drain();

    // popq-like: same register twice, memory result wins.
    send(4'd4, 64'h100, 4'd4, 64'h77);
    drain();

    // Three two-write bundles back to back fill the buffer.
    saw_not_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(4'd1, 64'hE0 + 64'(k), 4'd2, 64'hA0 + 64'(k));
    drain();
    chk("ready_dropped", saw_not_ready, 1'b1);

    // Decode stall on a pending register.
    rd_srcA = 4'd5;
    rd_srcB = 4'hF;
    send(4'd5, 64'hDEAD, 4'hF, 64'h0);
    @(negedge clk);
    #1;
    chk("stall_during_write", rd_stall, 1'b1);
    @(negedge clk);
    #1;
    chk("stall_after_write", rd_stall, 1'b0);
    rd_srcA = 4'hF;
    idle(1);

    // Destination-less bundle is swallowed.
    send(4'hF, 64'h1, 4'hF, 64'h2);
    idle(3);

    // Reset while the first of two writes is on the port.
    send(4'd6, 64'h600, 4'd7, 64'h700);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_we", rf_we, 1'b0);
    chk("rst_mid_pend", pend_mask, '0);
    chk("rst_mid_busy", busy, 1'b0);
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_rst", wb_ready, 1'b1);
    idle(1);

    // Randomized traffic with random decode sources.
    rand_src = 1'b1;
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 3) != 0) send(rnd_dst(), {$urandom, $urandom}, rnd_dst(), {$urandom, $urandom});
      else idle(1);
    end
    drain();
    rand_src = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
